vchg_recorder: RTL and testbench

Value-change recorder: watches a multi-bit signal, applies an inertial (minimum-stable-time) filter, and logs each accepted change as a {timestamp, value} record into an internal FIFO. A consumer drains the FIFO over a valid/ready handshake. It is the receive side of the delayed value-put scheduler: that block drives scheduled, inertial, cancellable values onto a net, and this block observes the net and reports what actually settled and when.

---
 rtl/vchg_pkg.sv | 21 ++
 rtl/vchg_fifo.sv | 58 +++++
 rtl/vchg_recorder.sv | 87 ++++++++
 tb/tb_vchg_recorder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vchg_pkg.sv
// Shared types and constants for the value-change recorder and its FIFO.
package vchg_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_TS_WIDTH = 32;

  // Drop counter ceiling; ovf_cnt sticks here once reached.
  localparam int OVF_SAT = 255;

  // Record layout at the default widths: timestamp in the upper field.
  typedef struct packed {
    logic [DEF_TS_WIDTH-1:0] ts;
    logic [DEF_WIDTH-1:0]    value;
  } vchg_rec_t;

  // Pointer width: one bit more than the address so full and empty differ.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vchg_fifo.sv
// Synchronous FIFO with a registered head; write-through bypass keeps the head valid one cycle after a push.
module vchg_fifo
  import vchg_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [DW-1:0] dout_reg;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the same edge frees a slot.
  assign do_push = push && (!full || do_pop);

  assign rd_ptr_next = rd_ptr_reg + PW'(do_pop);
  assign level       = wr_ptr_reg - rd_ptr_reg;
  assign dout        = dout_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      dout_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(do_push);
      rd_ptr_reg <= rd_ptr_next;
      // The slot being written is the next head only when it lands in an otherwise-empty FIFO.
      if (do_push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]))
        dout_reg <= din;
      else
        dout_reg <= mem[rd_ptr_next[AW-1:0]];
    end
  end

endmodule

// File: rtl/vchg_recorder.sv
// Value-change recorder: inertially filters a watched signal and queues {timestamp, value} records.
module vchg_recorder
  import vchg_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int TS_WIDTH = 32,
  parameter int DEPTH    = 8,
  parameter int HOLD     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIDTH-1:0]       sig_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TS_WIDTH-1:0]    out_time,
  output logic [WIDTH-1:0]       out_value,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic [7:0]             ovf_cnt
);

  logic [TS_WIDTH-1:0]       tcnt_reg, cand_t_reg;
  logic [WIDTH-1:0]          last_reg, cand_reg;
  logic [7:0]                stab_reg;
  logic                      ovf_reg;
  logic [7:0]                ovf_cnt_reg;
  logic                      push, pop, drop, full, empty;
  logic [TS_WIDTH+WIDTH-1:0] head;

  // Accept once the candidate has survived HOLD further stable edges.
  assign push = en && (sig_in == cand_reg) && (cand_reg != last_reg) &&
                (stab_reg == 8'(HOLD));
  assign pop  = out_valid && out_ready;
  assign drop = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_reg    <= '0;
      last_reg    <= '0;
      cand_reg    <= '0;
      cand_t_reg  <= '0;
      stab_reg    <= '0;
      ovf_reg     <= 1'b0;
      ovf_cnt_reg <= '0;
    end else begin
      tcnt_reg <= tcnt_reg + TS_WIDTH'(1);
      if (en) begin
        if (sig_in != cand_reg) begin
          cand_reg   <= sig_in;
          cand_t_reg <= tcnt_reg;
          stab_reg   <= '0;
        end else if (cand_reg != last_reg) begin
          // last follows the settled value even when the record is dropped.
          if (stab_reg == 8'(HOLD)) last_reg <= cand_reg;
          else                      stab_reg <= stab_reg + 8'd1;
        end
      end
      if (drop) begin
        ovf_reg <= 1'b1;
        if (ovf_cnt_reg != 8'(OVF_SAT)) ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
      end
    end
  end

  vchg_fifo #(
    .DW    (TS_WIDTH + WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({cand_t_reg, cand_reg}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid = !empty;
  assign out_time  = head[WIDTH +: TS_WIDTH];
  assign out_value = head[WIDTH-1:0];
  assign ovf       = ovf_reg;
  assign ovf_cnt   = ovf_cnt_reg;

endmodule

// File: tb/tb_vchg_recorder.sv
// Scoreboard bench: three recorders (HOLD 0/2/3); expected records are queued at stimulus time, monitors pop them.
module tb_vchg_recorder;
  import vchg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en0, rdy0, rdy2, rdy3;
  logic [31:0] sig0, sig2, sig3;
  logic        v0, v2, v3, ovf0, ovf2, ovf3;
  logic [31:0] t0, t2, t3, val0, val2, val3;
  logic [3:0]  lvl0, lvl2, lvl3;
  logic [7:0]  oc0, oc2, oc3;

  int checks = 0;
  int failures = 0;
  int cyc;
  vchg_rec_t q0[$];
  vchg_rec_t q3[$];
  vchg_rec_t e0, e3;

  vchg_recorder #(.WIDTH(32), .TS_WIDTH(32), .DEPTH(8), .HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .sig_in(sig0), .out_valid(v0), .out_ready(rdy0),
    .out_time(t0), .out_value(val0), .level(lvl0), .ovf(ovf0), .ovf_cnt(oc0));

  vchg_recorder #(.WIDTH(32), .TS_WIDTH(32), .DEPTH(8), .HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .en(1'b1), .sig_in(sig2), .out_valid(v2), .out_ready(rdy2),
    .out_time(t2), .out_value(val2), .level(lvl2), .ovf(ovf2), .ovf_cnt(oc2));

  vchg_recorder #(.WIDTH(32), .TS_WIDTH(32), .DEPTH(8), .HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .en(1'b1), .sig_in(sig3), .out_valid(v3), .out_ready(rdy3),
    .out_time(t3), .out_value(val3), .level(lvl3), .ovf(ovf3), .ovf_cnt(oc3));

  // Reference edge count: equals the tcnt value the next rising edge will sample.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (v0 && rdy0) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL d0_unexpected actual=%0h/%0h required=none", t0, val0);
      end else begin
        e0 = q0.pop_front();
        $display("d0 rec time=%0d value=%08h", t0, val0);
        chk("d0_time", {32'd0, t0}, {32'd0, e0.ts});
        chk("d0_value", {32'd0, val0}, {32'd0, e0.value});
      end
    end
  end

  always @(negedge clk) begin
    if (v3 && rdy3) begin
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL d3_unexpected actual=%0h/%0h required=none", t3, val3);
      end else begin
        e3 = q3.pop_front();
        $display("d3 rec time=%0d value=%08h", t3, val3);
        chk("d3_time", {32'd0, t3}, {32'd0, e3.ts});
        chk("d3_value", {32'd0, val3}, {32'd0, e3.value});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Change sig0 and hold two edges: capture edge, then the accepting edge (HOLD=0).
  task automatic apply0(input logic [31:0] v, input bit expect_rec);
    sig0 = v;
    if (expect_rec) q0.push_back('{ts: cyc, value: v});
    steps(2);
  endtask

  task automatic drain0(input int bound, input bit random_ready);
    for (int i = 0; i < bound; i++) begin
      if (lvl0 == 0) break;
      rdy0 = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    rdy0 = 1'b1;
    chk("d0_drain_level", {60'd0, lvl0}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; en0 = 1'b1; rdy0 = 1'b0; rdy2 = 1'b1; rdy3 = 1'b1;
    sig0 = '0; sig2 = '0; sig3 = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", {63'd0, v0}, 64'd0);
    chk("rst_level", {60'd0, lvl0}, 64'd0);
    chk("rst_ovf", {63'd0, ovf0}, 64'd0);
    chk("rst_ovf_cnt", {56'd0, oc0}, 64'd0);
    chk("rst_time", {32'd0, t0}, 64'd0);
    chk("rst_value", {32'd0, val0}, 64'd0);
    rst = 1'b0;

    // First edge after release samples tcnt=0; the change lands before edge 10.
    steps(10);
    sig0 = 32'h55AA;
    q0.push_back('{ts: 32'd10, value: 32'h55AA});
    step();
    chk("lat_edge0_valid", {63'd0, v0}, 64'd0);
    step();
    chk("lat_edge1_valid", {63'd0, v0}, 64'd1);
    chk("lat_level", {60'd0, lvl0}, 64'd1);
    drain0(20, 1'b0);

    // Ten accepted changes into an undrained 8-deep FIFO: two are dropped.
    rdy0 = 1'b0;
    for (int i = 0; i < 10; i++) apply0(32'h100 + 32'(i), i < 8);
    chk("ovf_level", {60'd0, lvl0}, 64'd8);
    chk("ovf_flag", {63'd0, ovf0}, 64'd1);
    chk("ovf_cnt", {56'd0, oc0}, 64'd2);
    drain0(40, 1'b0);

    // Refill, then push and pop on the same edge while full.
    rdy0 = 1'b0;
    for (int i = 0; i < 8; i++) apply0(32'h200 + 32'(i), 1'b1);
    chk("full_level", {60'd0, lvl0}, 64'd8);
    sig0 = 32'h2FF;
    q0.push_back('{ts: cyc, value: 32'h2FF});
    step();
    rdy0 = 1'b1;
    step();
    rdy0 = 1'b0;
    chk("pushpop_level", {60'd0, lvl0}, 64'd8);
    chk("pushpop_ovf_cnt", {56'd0, oc0}, 64'd2);
    drain0(200, 1'b1);

    // HOLD=3: a 2-edge pulse is filtered, a held value is stamped at its first edge.
    sig3 = 32'hAA55;
    steps(2);
    sig3 = 32'h0;
    steps(6);
    chk("pulse3_level", {60'd0, lvl3}, 64'd0);
    chk("pulse3_valid", {63'd0, v3}, 64'd0);
    sig3 = 32'hAA55;
    q3.push_back('{ts: cyc, value: 32'hAA55});
    steps(4);
    chk("hold3_valid_early", {63'd0, v3}, 64'd0);
    step();
    chk("hold3_valid", {63'd0, v3}, 64'd1);
    steps(2);
    chk("hold3_drained", {60'd0, lvl3}, 64'd0);

    // HOLD=2: value returns to last one edge before it would be accepted.
    sig2 = 32'h20;
    steps(3);
    sig2 = 32'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("cancel2_level", {60'd0, lvl2}, 64'd0);
    end
    chk("cancel2_valid", {63'd0, v2}, 64'd0);

    // Disabled capture ignores the change until the first enabled edge.
    en0 = 1'b0;
    sig0 = 32'hFFFF_FFFF;
    steps(3);
    chk("en_off_level", {60'd0, lvl0}, 64'd0);
    en0 = 1'b1;
    q0.push_back('{ts: cyc, value: 32'hFFFF_FFFF});
    steps(2);
    drain0(10, 1'b0);

    // Reset with three records queued, then a nonzero input seen as a change from 0.
    rdy0 = 1'b0;
    apply0(32'h1, 1'b1);
    apply0(32'h2, 1'b1);
    apply0(32'h3, 1'b1);
    chk("pre_rst_level", {60'd0, lvl0}, 64'd3);
    sig0 = 32'h77;
    rst = 1'b1;
    step();
    chk("mid_rst_level", {60'd0, lvl0}, 64'd0);
    chk("mid_rst_valid", {63'd0, v0}, 64'd0);
    chk("mid_rst_ovf", {63'd0, ovf0}, 64'd0);
    chk("mid_rst_ovf_cnt", {56'd0, oc0}, 64'd0);
    q0.delete();
    rst = 1'b0;
    q0.push_back('{ts: 32'd0, value: 32'h77});
    rdy0 = 1'b1;
    steps(2);
    drain0(10, 1'b0);

    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q3_empty", 64'(q3.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
